mem_fill_engine: RTL

- Hardware memset/fill engine: writes a programmable pattern into data memory over a contiguous word range, replacing software store loops.
- Sits beside the processor on the data-memory write port and is muxed in while busy; memory is byte-addressed, little-endian, word-aligned.
- Generalises the software memset with parametrised widths, a length counter, a ready handshake, and a constant or incrementing pattern mode.

---
 rtl/mem_fill_engine.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_fill_engine.sv
// Hardware memset engine: streams a constant or incrementing pattern into a word range.
// Optional abort/aborted ports are enabled by defining MEM_FILL_ABORT_EN.
module mem_fill_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  word_count,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic                  incr_mode,
`ifdef MEM_FILL_ABORT_EN
  input  logic                  abort,
  output logic                  aborted,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~(ADDR_STRIDE - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  incr_q, incr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic                  abort_req;

`ifdef MEM_FILL_ABORT_EN
  logic                  aborted_q, aborted_d;
  assign abort_req = abort;
  assign aborted   = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    incr_d      = incr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    we_d        = we_q;
`ifdef MEM_FILL_ABORT_EN
    aborted_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = dst_addr & ALIGN_MASK;
          wdata_d     = pattern;
          incr_d      = incr_mode;
          remaining_d = word_count;
          if (word_count != '0) begin
            state_d = S_FILL;
            busy_d  = 1'b1;
            we_d    = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        // remaining is always >= 1 here, so the decrement cannot underflow
        if (mem_ready) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          addr_d      = addr_q + ADDR_STRIDE;
          if (incr_q) begin
            wdata_d = wdata_q + DATA_WIDTH'(1);
          end else begin
            wdata_d = wdata_q;
          end
        end else begin
          remaining_d = remaining_q;
        end
        if ((mem_ready && (remaining_q == LEN_WIDTH'(1))) || abort_req) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_FILL;
        end
`ifdef MEM_FILL_ABORT_EN
        aborted_d = abort_req;
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        we_d    = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      incr_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
`ifdef MEM_FILL_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      incr_q      <= incr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      we_q        <= we_d;
`ifdef MEM_FILL_ABORT_EN
      aborted_q   <= aborted_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
